// File: rtl/bram_port_arbiter_if.sv
// Two-client request/ack bundle plus the BRAM port A signals for bram_port_arbiter.
// slave is the arbiter's view; master is the clients/BRAM side.
interface bram_port_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] din0;
   logic              ack0;
   logic              rvalid0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] din1;
   logic              ack1;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata1;

   logic              ena;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina;
   logic [DATA_W-1:0] douta;

   modport slave (
      input  req0, we0, addr0, din0, req1, we1, addr1, din1, douta,
      output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, ena, wea, addra, dina
   );

   modport master (
      output req0, we0, addr0, din0, req1, we1, addr1, din1, douta,
      input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, ena, wea, addra, dina
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between two clients,
// with a read-latency pipeline that returns a per-port read-valid strobe.
module bram_port_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 2
) (
   input logic                clka,
   input logic                rsta,
   bram_port_arbiter_if.slave bus
);

   logic              elig0_c, elig1_c, grant0_c, grant1_c;
   logic              prio1_q, prio1_d;
   logic              ena_q, ena_d;
   logic              wea_q, wea_d;
   logic [ADDR_W-1:0] addra_q, addra_d;
   logic [DATA_W-1:0] dina_q, dina_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
   logic [RD_LAT-1:0] rd_tag_q, rd_tag_d;

   // Grant selection, BRAM command capture and read-return tracking
   always_comb begin
      ena_d     = 1'b0;
      wea_d     = 1'b0;
      addra_d   = addra_q;
      dina_d    = dina_q;
      prio1_d   = prio1_q;

      // A just-acked port is masked: its requester has not yet moved on
      elig0_c   = bus.req0 & ~ack0_q;
      elig1_c   = bus.req1 & ~ack1_q;
      grant0_c  = elig0_c & (~elig1_c | ~prio1_q);
      grant1_c  = elig1_c & ~grant0_c;

      ack0_d    = grant0_c;
      ack1_d    = grant1_c;

      if (grant0_c) begin
         ena_d   = 1'b1;
         wea_d   = bus.we0;
         addra_d = bus.addr0;
         dina_d  = bus.din0;
         prio1_d = 1'b1;
      end else if (grant1_c) begin
         ena_d   = 1'b1;
         wea_d   = bus.we1;
         addra_d = bus.addr1;
         dina_d  = bus.din1;
         prio1_d = 1'b0;
      end

      // Stage 0 corresponds to the ack cycle; the tail lands RD_LAT cycles later
      rd_vld_d  = RD_LAT'({rd_vld_q, ena_d & ~wea_d});
      rd_tag_d  = RD_LAT'({rd_tag_q, grant1_c});
      rvalid0_d = rd_vld_q[RD_LAT-1] & ~rd_tag_q[RD_LAT-1];
      rvalid1_d = rd_vld_q[RD_LAT-1] &  rd_tag_q[RD_LAT-1];
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         prio1_q   <= 1'b0;
         ena_q     <= 1'b0;
         wea_q     <= 1'b0;
         addra_q   <= '0;
         dina_q    <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rd_vld_q  <= '0;
         rd_tag_q  <= '0;
      end else begin
         prio1_q   <= prio1_d;
         ena_q     <= ena_d;
         wea_q     <= wea_d;
         addra_q   <= addra_d;
         dina_q    <= dina_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rd_vld_q  <= rd_vld_d;
         rd_tag_q  <= rd_tag_d;
      end
   end

   assign bus.ena     = ena_q;
   assign bus.wea     = wea_q;
   assign bus.addra   = addra_q;
   assign bus.dina    = dina_q;
   assign bus.ack0    = ack0_q;
   assign bus.ack1    = ack1_q;
   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata0  = bus.douta;
   assign bus.rdata1  = bus.douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: RD_LAT=2 and RD_LAT=1 instances,
// each attached to a behavioural 256x8 BRAM model.
module tb_bram_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n0, n1;
   logic e_ena, e_a0, e_a1, e_r0, e_r1;

   bram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus  ();
   bram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

   bram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut (
      .clka (clk),
      .rsta (rst),
      .bus  (bus)
   );

   bram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut1 (
      .clka (clk),
      .rsta (rst),
      .bus  (bus1)
   );

   always #5 clk = ~clk;

   // BRAM models: two-stage read for dut, one-stage for dut1; preload mem[i]=0x80+i on reset
   logic [7:0] mem  [256];
   logic [7:0] mem1 [256];
   logic [7:0] stg;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(8'h80 + i);
      end else if (bus.ena) begin
         if (bus.wea) mem[bus.addra] <= bus.dina;
         else         stg <= mem[bus.addra];
      end
      bus.douta <= stg;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem1[i] <= 8'(8'h80 + i);
      end else if (bus1.ena) begin
         if (bus1.wea) mem1[bus1.addra] <= bus1.dina;
         else          bus1.douta <= mem1[bus1.addra];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.din0 = 8'h00;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.din1 = 8'h00;
      bus.douta = 8'h00;
      bus1.req0 = 1'b0; bus1.we0 = 1'b0; bus1.addr0 = 8'h00; bus1.din0 = 8'h00;
      bus1.req1 = 1'b0; bus1.we1 = 1'b0; bus1.addr1 = 8'h00; bus1.din1 = 8'h00;
      bus1.douta = 8'h00;

      // Reset hold with both requests high
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("rst_hold", 32'({bus.ena, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1, bus1.ena}), 32'd0);
      end
      rst = 1'b0;
      tick();
      check_eq("first_grant", 32'({bus.ena, bus.wea, bus.ack0, bus.ack1}), 32'b1010);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tick();
      check_eq("dropped_req1", 32'({bus.ena, bus.ack0, bus.ack1}), 32'b000);
      tick();
      check_eq("first_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'b10);
      check_eq("first_rdata", 32'(bus.rdata0), 32'h80);
      tick();
      check_eq("first_rv_end", 32'({bus.rvalid0, bus.rvalid1}), 32'b00);

      // Port 0 write 0x10=0xA5 then read it back
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.din0 = 8'hA5;
      tick();
      check_eq("wr_cmd", 32'({bus.ena, bus.wea, bus.ack0, bus.addra, bus.dina}), 32'({3'b111, 8'h10, 8'hA5}));
      bus.we0 = 1'b0;
      tick();
      check_eq("wr_gap", 32'({bus.ena, bus.ack0}), 32'b00);
      tick();
      check_eq("rd_cmd", 32'({bus.ena, bus.wea, bus.ack0, bus.addra}), 32'({3'b101, 8'h10}));
      bus.req0 = 1'b0;
      tick();
      check_eq("rd_wait", 32'({bus.rvalid0, bus.rvalid1}), 32'b00);
      tick();
      check_eq("rd_rv", 32'({bus.rvalid0, bus.rvalid1}), 32'b10);
      check_eq("rd_data", 32'(bus.rdata0), 32'hA5);
      tick();
      check_eq("rd_rv_end", 32'({bus.rvalid0, bus.rvalid1}), 32'b00);

      // Port 1 write 0x30=0x77: no rvalid must follow
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h30; bus.din1 = 8'h77;
      tick();
      check_eq("p1_wr_cmd", 32'({bus.ena, bus.wea, bus.ack0, bus.ack1, bus.addra, bus.dina}), 32'({4'b1101, 8'h30, 8'h77}));
      bus.req1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("p1_wr_no_rv", 32'({bus.ena, bus.rvalid0, bus.rvalid1}), 32'b000);
      end

      // Contention at 0xFF: port 0 write, port 1 read
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'hFF; bus.din0 = 8'h3C;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'hFF;
      tick();
      check_eq("cont_g0", 32'({bus.ena, bus.wea, bus.ack0, bus.ack1, bus.addra}), 32'({4'b1110, 8'hFF}));
      bus.req0 = 1'b0;
      tick();
      check_eq("cont_g1", 32'({bus.ena, bus.wea, bus.ack0, bus.ack1, bus.addra}), 32'({4'b1001, 8'hFF}));
      bus.req1 = 1'b0;
      tick();
      check_eq("cont_idle", 32'({bus.ena, bus.rvalid0, bus.rvalid1}), 32'b000);
      tick();
      check_eq("cont_rv", 32'({bus.rvalid0, bus.rvalid1}), 32'b01);
      check_eq("cont_data", 32'(bus.rdata1), 32'h3C);
      tick();
      check_eq("cont_rv_end", 32'({bus.rvalid0, bus.rvalid1}), 32'b00);

      // Alternating reads: port 0 reads 0,2,4,6; port 1 reads 1,3,5,7
      n0 = 0; n1 = 0;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h00;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h01;
      for (int t = 0; t < 11; t++) begin
         tick();
         e_ena = (t < 8);
         e_a0  = (t < 8) && (t % 2 == 0);
         e_a1  = (t < 8) && (t % 2 == 1);
         e_r0  = (t >= 2) && (t < 10) && (t % 2 == 0);
         e_r1  = (t >= 2) && (t < 10) && (t % 2 == 1);
         check_eq("alt_ack", 32'({bus.ena, bus.ack0, bus.ack1}), 32'({e_ena, e_a0, e_a1}));
         if (e_ena) check_eq("alt_addra", 32'(bus.addra), 32'(t));
         check_eq("alt_rv", 32'({bus.rvalid0, bus.rvalid1}), 32'({e_r0, e_r1}));
         if (e_r0) check_eq("alt_rdata0", 32'(bus.rdata0), 32'(128 + t - 2));
         if (e_r1) check_eq("alt_rdata1", 32'(bus.rdata1), 32'(128 + t - 2));
         if (bus.ack0) begin
            n0++;
            if (n0 < 4) bus.addr0 = 8'(2 * n0);
            else        bus.req0 = 1'b0;
         end
         if (bus.ack1) begin
            n1++;
            if (n1 < 4) bus.addr1 = 8'(2 * n1 + 1);
            else        bus.req1 = 1'b0;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;

      // Reset one cycle after a read grant discards the return
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h05;
      tick();
      check_eq("mid_ack", 32'({bus.ena, bus.ack0}), 32'b11);
      bus.req0 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_eq("mid_rst_rv", 32'({bus.ena, bus.rvalid0, bus.rvalid1}), 32'b000);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("mid_post_rv", 32'({bus.rvalid0, bus.rvalid1}), 32'b00);
      end

      // RD_LAT=1 instance: read 0x20 returns one cycle after ack
      bus1.req0 = 1'b1; bus1.we0 = 1'b0; bus1.addr0 = 8'h20;
      tick();
      check_eq("lat1_ack", 32'({bus1.ena, bus1.ack0, bus1.rvalid0}), 32'b110);
      bus1.req0 = 1'b0;
      tick();
      check_eq("lat1_rv", 32'({bus1.ena, bus1.rvalid0, bus1.rvalid1}), 32'b010);
      check_eq("lat1_data", 32'(bus1.rdata0), 32'hA0);
      tick();
      check_eq("lat1_rv_end", 32'({bus1.rvalid0, bus1.rvalid1}), 32'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port block RAM (blk_mem_gen_1, 256 x 8) between two requesters using round-robin arbitration.
- Drives the BRAM's ena/wea/addra/dina as registered outputs.
- Tracks in-flight reads through a latency pipeline and returns a read-valid strobe to the requester that issued each read.
- Sits between the BRAM instance and two client blocks, e.g. a capture writer and a readout engine.

Parameters:
- ADDR_W, 8, address width; matches BRAM addra.
- DATA_W, 8, data width; matches BRAM dina/douta.
- RD_LAT, 2, BRAM read latency in cycles: 1 = primitive output only, 2 = primitive output register enabled. Legal values are 1..4.

Ports:
- clka  in  1  clock, shared with the BRAM
- rsta  in  1  synchronous active-high reset
- req0  in  1  port 0 request; hold high with we0/addr0/din0 stable until ack0
- we0  in  1  port 0 operation: 1 = write, 0 = read
- addr0  in  ADDR_W  port 0 address
- din0  in  DATA_W  port 0 write data
- ack0  out  1  port 0 grant: one-cycle pulse, high in the cycle the op is presented to the BRAM
- rvalid0  out  1  port 0 read data valid, one-cycle pulse
- rdata0  out  DATA_W  port 0 read data, equal to douta
- req1, we1, addr1, din1, ack1, rvalid1, rdata1: same as port 0, for port 1
- ena  out  1  BRAM enable
- wea  out  1  BRAM write enable, [0:0]
- addra  out  ADDR_W  BRAM address
- dina  out  DATA_W  BRAM write data
- douta  in  DATA_W  BRAM read data

Behaviour:
- One clock (clka). Reset rsta is synchronous and active-high.
- Reset values: ena=0, wea=0, addra=0, dina=0, ack0=ack1=0, rvalid0=rvalid1=0. Read pipeline cleared. Round-robin pointer set so port 0 wins the first conflict.
- Eligibility at each edge: port N is eligible if reqN=1 and ackN=0 in the current cycle. The ackN mask blocks re-issue of the op just acknowledged, because the requester only updates its signals at the next edge.
- Grant:
  - Exactly one eligible port: that port is granted.
  - Both eligible: the port not granted last is granted; the pointer then updates to the winner.
  - Pointer changes only on a grant.
- On the grant edge, register ena=1, wea=weN, addra=addrN, dina=dinN and ackN=1. All four BRAM signals and ackN are high/valid in the same cycle.
- No eligible port: ena=0 and wea=0; addra/dina hold their last value.
- Throughput:
  - A single requester achieves at most one op per 2 cycles.
  - Two requesters holding req high alternate 0,1,0,1 with ena=1 every cycle.
- Read return:
  - A read granted with ack in cycle c produces rvalidN=1 in cycle c+RD_LAT, exactly one cycle wide, tagged to the issuing port.
  - Writes never produce rvalid.
  - rdata0 and rdata1 are both wired to douta; they are meaningful only while the matching rvalid is high.
- Ordering: returns occur in grant order. Back-to-back reads from alternating ports return on consecutive cycles.
- Address is used modulo 2^ADDR_W; 0xFF is an ordinary location with no wrap logic.
- A request deasserted before ack is dropped silently; no ack is generated.
- Reset mid-operation: all in-flight reads are discarded (no rvalid after reset) and any pending grant is cancelled. Requests still held when rsta falls are arbitrated from the reset pointer state.
- Simultaneous read and write to the same address from different ports execute in grant order. A read granted after a write returns the new data.

Test Plan:
- Reset hold: rsta=1 for 3 cycles with req0=req1=1 -> ena, ack0/1 and rvalid0/1 stay 0. First edge after release gives ack0=1 (port 0 priority).
- Port 0 write 0x10=0xA5, then read 0x10, RD_LAT=2 -> ack0 in cycles c and c+2. rvalid0=1 in cycle c+4 only, with rdata0=0xA5. rvalid1 stays 0.
- Contention: both ports hold req continuously; port 0 writes 0xFF=0x3C, port 1 reads 0xFF -> ack0 then ack1 on consecutive cycles, ena=1 both cycles. rvalid1 fires 2 cycles after ack1 with rdata1=0x3C.
- Alternating reads of 0x00..0x07 from both ports -> ena=1 every cycle, acks alternate strictly, and rvalids alternate in grant order with correct data.
- Reset mid-read: read granted (ack0 in cycle c), rsta=1 in cycle c+1 -> no rvalid0 in cycle c+2 or later.
- RD_LAT=1 build: single read of 0x20 -> rvalid0 exactly 1 cycle after ack0.
